rr_response_router: RTL and testbench

Return-path companion to round_robin_arbiter: routes response data from slaves s1/s2 back to the master that issued each request.
- The arbiter pushes a (master, slave) tag into an in-order tag FIFO each time it forwards a request.
- The router accepts the response only from the slave at the FIFO head, registers it, and delivers it to the tagged master.
- All transfers use the codebase valid/ready handshake.

---
 rtl/rr_pkg.sv | 31 +++
 rtl/rr_tag_fifo.sv | 62 ++++++
 rtl/rr_response_router.sv | 168 ++++++++++++++++
 tb/tb_rr_response_router.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// ============================================================================
// Module      : rr_pkg
// Description : Shared encodings for the round-robin response return path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    localparam logic MASTER_M1 = 1'b0;
    localparam logic MASTER_M2 = 1'b1;
    localparam logic SLAVE_S1  = 1'b0;
    localparam logic SLAVE_S2  = 1'b1;

    localparam logic [7:0] ADDR_S1 = 8'hAA;
    localparam logic [7:0] ADDR_S2 = 8'hBB;

    typedef struct packed {
        logic master;
        logic slave;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/rr_tag_fifo.sv
// ============================================================================
// Module      : rr_tag_fifo
// Description : In-order (master, slave) tag FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_tag_fifo
    import rr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  tag_t                       i_tag,
    input  logic                       i_pop,
    output tag_t                       o_head,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    tag_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Full comes from the registered count, so a same-cycle pop never frees a slot early
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_tag;
    end

endmodule

`default_nettype wire

// File: rtl/rr_response_router.sv
// ============================================================================
// Module      : rr_response_router
// Description : Routes s1/s2 responses back to the issuing master, in order.
//               Optional macro RESP_TIMEOUT_EN adds a per-response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_response_router
    import rr_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_push,
    input  logic                       req_master,
    input  logic                       req_slave,
    output logic                       req_full,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    input  logic                       in_valid_s1,
    input  logic [DATA_W-1:0]          in_data_s1,
    output logic                       out_ready_s1,
    input  logic                       in_valid_s2,
    input  logic [DATA_W-1:0]          in_data_s2,
    output logic                       out_ready_s2,
    output logic                       out_valid_m1,
    output logic [DATA_W-1:0]          out_data_m1,
    input  logic                       in_ready_m1,
    output logic                       out_valid_m2,
    output logic [DATA_W-1:0]          out_data_m2,
    input  logic                       in_ready_m2,
    output logic                       resp_err
);

    localparam int c_CNT_W = $clog2(DEPTH+1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
            $error("rr_response_router: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    state_t              r_state;
    state_t              w_next;
    tag_t                w_head;
    tag_t                w_push_tag;
    logic [c_CNT_W-1:0]  w_count;
    logic                w_collect;
    logic                w_deliver;
    logic                w_timeout;
    logic                w_slave_valid;
    logic [DATA_W-1:0]   w_slave_data;
    logic                w_slave_hs;
    logic                w_master_hs;
    logic [DATA_W-1:0]   w_capture;
    logic [DATA_W-1:0]   r_data_m1;
    logic [DATA_W-1:0]   r_data_m2;

    assign w_push_tag = '{master: req_master, slave: req_slave};

    rr_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_push),
        .i_tag   (w_push_tag),
        .i_pop   (w_master_hs),
        .o_head  (w_head),
        .o_full  (req_full),
        .o_count (w_count)
    );

    assign outstanding = w_count;
    assign w_collect   = (r_state == ST_COLLECT);
    assign w_deliver   = (r_state == ST_DELIVER);

    assign w_slave_valid = (w_head.slave == SLAVE_S2) ? in_valid_s2 : in_valid_s1;
    assign w_slave_data  = (w_head.slave == SLAVE_S2) ? in_data_s2  : in_data_s1;

    // COLLECT/DELIVER are only reachable with a non-empty FIFO, so the head tag is valid here
    assign out_ready_s1 = w_collect && !w_timeout && (w_head.slave == SLAVE_S1);
    assign out_ready_s2 = w_collect && !w_timeout && (w_head.slave == SLAVE_S2);
    assign w_slave_hs   = w_collect && !w_timeout && w_slave_valid;

    assign out_valid_m1 = w_deliver && (w_head.master == MASTER_M1);
    assign out_valid_m2 = w_deliver && (w_head.master == MASTER_M2);
    assign w_master_hs  = w_deliver &&
                          ((w_head.master == MASTER_M2) ? in_ready_m2 : in_ready_m1);

    assign out_data_m1 = r_data_m1;
    assign out_data_m2 = r_data_m2;
    assign w_capture   = w_timeout ? {DATA_W{1'b1}} : w_slave_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_count != '0) w_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_slave_hs || w_timeout) w_next = ST_DELIVER;
            end
            ST_DELIVER: begin
                if (w_master_hs) begin
                    w_next = (w_count > c_CNT_W'(1)) ? ST_COLLECT : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Each master's output register doubles as the capture register, so it keeps its last value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_m1 <= '0;
            r_data_m2 <= '0;
        end else if (w_slave_hs || w_timeout) begin
            if (w_head.master == MASTER_M2) r_data_m2 <= w_capture;
            else                            r_data_m1 <= w_capture;
        end
    end

`ifdef RESP_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT+1);

    logic [c_TMR_W-1:0] r_timer;
    logic               r_err;

    assign w_timeout = w_collect && (r_timer == c_TMR_W'(TIMEOUT));
    assign resp_err  = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            if (!w_collect) begin
                r_timer <= '0;
            end else if (!w_slave_hs && !w_timeout) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_master_hs) begin
                r_err <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign resp_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_response_router.sv
// ============================================================================
// Module      : tb_rr_response_router
// Description : Directed self-checking bench for rr_response_router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_response_router;
    import rr_pkg::*;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_push, req_master, req_slave;
    logic       req_full;
    logic [2:0] outstanding;
    logic       in_valid_s1, out_ready_s1, in_valid_s2, out_ready_s2;
    logic [7:0] in_data_s1, in_data_s2;
    logic       out_valid_m1, in_ready_m1, out_valid_m2, in_ready_m2;
    logic [7:0] out_data_m1, out_data_m2;
    logic       resp_err;

    int n_cmp = 0;
    int n_err = 0;

    rr_response_router #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_push     (req_push),
        .req_master   (req_master),
        .req_slave    (req_slave),
        .req_full     (req_full),
        .outstanding  (outstanding),
        .in_valid_s1  (in_valid_s1),
        .in_data_s1   (in_data_s1),
        .out_ready_s1 (out_ready_s1),
        .in_valid_s2  (in_valid_s2),
        .in_data_s2   (in_data_s2),
        .out_ready_s2 (out_ready_s2),
        .out_valid_m1 (out_valid_m1),
        .out_data_m1  (out_data_m1),
        .in_ready_m1  (in_ready_m1),
        .out_valid_m2 (out_valid_m2),
        .out_data_m2  (out_data_m2),
        .in_ready_m2  (in_ready_m2),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic m, input logic s);
        req_push   = 1'b1;
        req_master = m;
        req_slave  = s;
        tick();
        req_push = 1'b0;
    endtask

    // Waits for the slave to be selected, returns one beat and checks it lands on master m
    task automatic serve(input logic s, input logic m, input logic [7:0] d, input string tag);
        for (int i = 0; i < 20 && !(s ? out_ready_s2 : out_ready_s1); i++) tick();
        check({tag, "_rdy"}, 32'(s ? out_ready_s2 : out_ready_s1), 32'd1);
        check({tag, "_other_rdy"}, 32'(s ? out_ready_s1 : out_ready_s2), 32'd0);
        if (s) begin in_valid_s2 = 1'b1; in_data_s2 = d; end
        else   begin in_valid_s1 = 1'b1; in_data_s1 = d; end
        tick();
        in_valid_s1 = 1'b0;
        in_valid_s2 = 1'b0;
        check({tag, "_vld"}, 32'(m ? out_valid_m2 : out_valid_m1), 32'd1);
        check({tag, "_data"}, 32'(m ? out_data_m2 : out_data_m1), 32'(d));
        check({tag, "_other_vld"}, 32'(m ? out_valid_m1 : out_valid_m2), 32'd0);
    endtask

    task automatic accept(input logic m);
        if (m) in_ready_m2 = 1'b1; else in_ready_m1 = 1'b1;
        tick();
        in_ready_m1 = 1'b0;
        in_ready_m2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_push = 0; req_master = 0; req_slave = 0;
        in_valid_s1 = 0; in_data_s1 = 0; in_valid_s2 = 0; in_data_s2 = 0;
        in_ready_m1 = 0; in_ready_m2 = 0;
        tick(); tick();
        rst = 1'b0;

        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_full", 32'(req_full), 32'd0);
        check("rst_valids", 32'({out_valid_m1, out_valid_m2}), 32'd0);
        check("rst_readies", 32'({out_ready_s1, out_ready_s2}), 32'd0);
        check("rst_data", 32'({out_data_m1, out_data_m2}), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);

        // single transaction m1 <- s1
        push(MASTER_M1, SLAVE_S1);
        check("t1_outstanding", 32'(outstanding), 32'd1);
        serve(SLAVE_S1, MASTER_M1, ADDR_S1, "t1");
        check("t1_m2_data", 32'(out_data_m2), 32'd0);
        check("t1_hold_out", 32'(outstanding), 32'd1);
        accept(MASTER_M1);
        check("t1_drained", 32'(outstanding), 32'd0);
        check("t1_vld_low", 32'(out_valid_m1), 32'd0);

        // ordering: s1 answers early but must wait behind s2
        push(MASTER_M1, SLAVE_S2);
        in_valid_s1 = 1'b1;
        in_data_s1  = 8'h55;
        push(MASTER_M2, SLAVE_S1);
        for (int i = 0; i < 20 && !out_ready_s2; i++) tick();
        check("t2_s2_rdy", 32'(out_ready_s2), 32'd1);
        tick(); tick();
        check("t2_s1_stalled", 32'(out_ready_s1), 32'd0);
        check("t2_out2", 32'(outstanding), 32'd2);
        check("t2_no_m2", 32'(out_valid_m2), 32'd0);
        in_valid_s2 = 1'b1;
        in_data_s2  = 8'hCC;
        tick();
        in_valid_s2 = 1'b0;
        check("t2_m1_vld", 32'(out_valid_m1), 32'd1);
        check("t2_m1_data", 32'(out_data_m1), 32'hCC);
        check("t2_m2_quiet", 32'(out_valid_m2), 32'd0);
        accept(MASTER_M1);
        check("t2_s1_rdy", 32'(out_ready_s1), 32'd1);
        tick();
        in_valid_s1 = 1'b0;
        check("t2_m2_vld", 32'(out_valid_m2), 32'd1);
        check("t2_m2_data", 32'(out_data_m2), 32'h55);
        check("t2_m1_hold", 32'(out_data_m1), 32'hCC);

        // backpressure on m2 for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_data_stable", 32'(out_data_m2), 32'h55);
            check("t3_vld_stable", 32'(out_valid_m2), 32'd1);
            check("t3_no_slave_rdy", 32'({out_ready_s1, out_ready_s2}), 32'd0);
        end
        check("t3_no_pop", 32'(outstanding), 32'd1);
        accept(MASTER_M2);
        check("t3_drained", 32'(outstanding), 32'd0);

        // fill past DEPTH; fifth tag must be dropped
        push(MASTER_M1, SLAVE_S1);
        push(MASTER_M2, SLAVE_S2);
        push(MASTER_M1, SLAVE_S2);
        check("t4_not_full3", 32'(req_full), 32'd0);
        push(MASTER_M2, SLAVE_S1);
        check("t4_full", 32'(req_full), 32'd1);
        push(MASTER_M2, SLAVE_S2);
        check("t4_out4", 32'(outstanding), 32'd4);
        serve(SLAVE_S1, MASTER_M1, 8'h11, "t4a");
        req_push = 1'b1; req_master = MASTER_M1; req_slave = SLAVE_S1;
        accept(MASTER_M1);
        req_push = 1'b0;
        check("t4_pop_push_full", 32'(outstanding), 32'd3);
        check("t4_full_clear", 32'(req_full), 32'd0);
        serve(SLAVE_S2, MASTER_M2, 8'h22, "t4b");
        accept(MASTER_M2);
        serve(SLAVE_S2, MASTER_M1, 8'h33, "t4c");
        accept(MASTER_M1);
        serve(SLAVE_S1, MASTER_M2, 8'h44, "t4d");
        accept(MASTER_M2);
        check("t4_empty", 32'(outstanding), 32'd0);
        tick(); tick();
        check("t4_idle_rdy", 32'({out_ready_s1, out_ready_s2}), 32'd0);

        // reset during DELIVER
        push(MASTER_M2, SLAVE_S1);
        serve(SLAVE_S1, MASTER_M2, 8'h77, "t5");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valids", 32'({out_valid_m1, out_valid_m2}), 32'd0);
        check("t5_readies", 32'({out_ready_s1, out_ready_s2}), 32'd0);
        check("t5_outstanding", 32'(outstanding), 32'd0);
        check("t5_data_lost", 32'(out_data_m2), 32'd0);
        tick(); tick();
        check("t5_stay_idle", 32'({out_valid_m2, out_ready_s1}), 32'd0);

`ifdef RESP_TIMEOUT_EN
        begin
            int n;
            push(MASTER_M2, SLAVE_S1);
            for (int i = 0; i < 20 && !out_ready_s1; i++) tick();
            check("t6_rdy", 32'(out_ready_s1), 32'd1);
            n = 0;
            while (out_ready_s1 && n < 40) begin
                n++;
                tick();
            end
            check("t6_wait_cycles", 32'(n), 32'(TIMEOUT));
            check("t6_no_vld_yet", 32'(out_valid_m2), 32'd0);
            tick();
            check("t6_vld", 32'(out_valid_m2), 32'd1);
            check("t6_data", 32'(out_data_m2), 32'hFF);
            check("t6_err", 32'(resp_err), 32'd1);
            accept(MASTER_M2);
            check("t6_err_clr", 32'(resp_err), 32'd0);
            check("t6_drained", 32'(outstanding), 32'd0);
        end
`else
        push(MASTER_M2, SLAVE_S1);
        for (int i = 0; i < 40; i++) tick();
        check("t6_waits", 32'(out_ready_s1), 32'd1);
        check("t6_no_vld", 32'(out_valid_m2), 32'd0);
        check("t6_err_zero", 32'(resp_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
